regfile_wr_arbiter: RTL and testbench
=====================================

# regfile_wr_arbiter

Shares the single write port (WE3/A3/WD3) of the 32x32 register file between two writeback requesters: requester 0 (ALU/execute writeback) and requester 1 (load/memory writeback). Each requester has a one-entry holding slot behind a valid/ready handshake. A per-cycle arbiter drains the slots into a registered write-port driver. The block also exports a pending-write mask that the hazard logic uses to stall reads of registers with writes in flight.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 5, register address width (2**ADDR_W registers)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has a write
- req0_addr  in  ADDR_W  requester 0 destination register
- req0_data  in  DATA_W  requester 0 write data
- req0_ready  out  1  slot 0 can accept this cycle
- req1_valid / req1_addr / req1_data / req1_ready  same as requester 0, for requester 1
- WE3  out  1  register file write enable (registered)
- A3  out  ADDR_W  register file write address (registered)
- WD3  out  DATA_W  register file write data (registered)
- pend_mask  out  2**ADDR_W  bit k set while a write to register k sits in a slot or on the WE3 output stage

## Operation
- Each slot has two states, EMPTY and FULL, and holds addr, data and age.
  - EMPTY→FULL: on reqN_valid & reqN_ready, when addr≠0.
  - FULL→EMPTY: when the slot is granted.
  - FULL→FULL: when the slot is granted and accepts a new request in the same cycle.
- reqN_ready = slot EMPTY or slot granted this cycle (combinational from slot state and grant). reqN_ready does not depend on reqN_valid.
- Writes to address 0 are accepted (handshake completes) but discarded. The slot stays EMPTY, nothing appears on WE3, and no pend_mask bit is set.
- Age tracking: a slot loading while the other slot is FULL and not granted becomes "younger". If both slots load in the same cycle, slot 0 is older.
- Arbitration each cycle, among FULL slots:
  - Only one FULL: grant it.
  - Both FULL, same addr: grant the older slot (write ordering preserved).
  - Both FULL, different addr: use the policy set under Configuration.
- Output stage on each clock edge:
  - WE3 ← any grant; A3/WD3 ← granted slot contents.
  - With no grant: WE3 ← 0, and A3/WD3 hold their previous values.
- pend_mask = decode(slot0 addr if FULL) | decode(slot1 addr if FULL) | decode(A3 if WE3).
- Reset values: both slots EMPTY, WE3=0, A3=0, WD3=0, pend_mask=0, round-robin pointer=0, req0_ready=req1_ready=1 (combinational after reset).

## Timing
- Accept in cycle N → slot FULL in N+1. If granted in N+1, WE3 is high in N+2 and the register file writes at the end of N+2. Minimum latency is 2 cycles.
- Throughput: one write per cycle total. A single requester can stream back-to-back when uncontested.
- Contention: the losing slot waits and its ready stays low. No slot waits more than one cycle under round-robin; under fixed priority requester 1 can starve.
- Reset asserted mid-operation:
  - Held slot contents are dropped and WE3 deasserts immediately (asynchronous).
  - No partial write is issued after reset releases.
- Simultaneous accept and grant on the same slot: the new entry is visible the following cycle, and the old entry goes out on WE3.

## Configuration
- RR_ARB_EN defined: a 1-bit round-robin pointer selects between two FULL, different-address slots. The pointer then moves to the non-granted requester. It updates only on contested grants.
- RR_ARB_EN undefined: fixed priority, requester 0 wins. The pointer logic is not built.
- Same-address age ordering applies in both builds.

## Structure
- The shared package holds:
  - DATA_W and ADDR_W defaults, NREG = 2**ADDR_W.
  - slot state encoding (SLOT_EMPTY, SLOT_FULL).
  - the slot record typedef (addr, data, full, age).
- One sub-module, wr_slot: holding register plus EMPTY/FULL state, instantiated twice. The arbiter, output stage and pend_mask decode stay in the top module.

## Test plan
- Reset mid-stream: both slots FULL, assert rst → WE3=0 in the same cycle, pend_mask=0, both readies high; after release, no WE3 pulse occurs without new requests.
- Single request: req0 valid, addr=5, data=0xDEADBEEF in cycle 0 → WE3=1, A3=5, WD3=0xDEADBEEF in cycle 2; pend_mask[5] set in cycles 1–2, then clear.
- x0 discard: req1 valid, addr=0, data=0x1234 → req1_ready=1, WE3 never asserts, pend_mask stays 0.
- Contention, different addresses (both requests in the same cycle), req0 addr=3 and req1 addr=7:
  - Fixed build: A3=3 then A3=7 on consecutive cycles.
  - RR build, with pointer pre-set to 1 by a previous contest: A3=7 then A3=3.
- Same address, ordering: req1 writes addr=9, data=0xAA in cycle 0; req0 writes addr=9, data=0xBB in cycle 1 while slot 1 is held by contention → writes issue as 0xAA then 0xBB; final register 9 = 0xBB in both builds.
- Streaming: req0 valid for 8 consecutive cycles, addr=1..8, req1 idle → req0_ready stays high throughout, and WE3 is high for 8 consecutive cycles with A3=1..8 in order.

Source files
------------

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
package regfile_wr_arbiter_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NREG   = 1 << ADDR_W;

    // Holding slot occupancy
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Snapshot of one holding slot; age=1 marks the younger of two held entries
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              full;
        logic              age;
    } slot_t;

endpackage

// File: rtl/regfile_wr_arbiter_slot.sv
// One-entry writeback holding slot with EMPTY/FULL state and relative age bit.
module wr_slot #(
    parameter int unsigned DATA_W = regfile_wr_arbiter_pkg::DATA_W,
    parameter int unsigned ADDR_W = regfile_wr_arbiter_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_young,
    input  logic              other_load,
    input  logic              grant,
    output logic              full,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              young
);
    import regfile_wr_arbiter_pkg::*;

    slot_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              young_q;

    // Next state: a grant drains the slot, a load (possibly same cycle) refills it
    always_comb begin
        state_d = state_q;
        if (grant) state_d = SLOT_EMPTY;
        if (load)  state_d = SLOT_FULL;
    end

    // State, payload and age registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            addr_q  <= '0;
            data_q  <= '0;
            young_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                addr_q  <= load_addr;
                data_q  <= load_data;
                young_q <= load_young;
            end else if (other_load) begin
                // Whatever we hold predates the entry arriving in the other slot
                young_q <= 1'b0;
            end
        end
    end

    assign full  = (state_q == SLOT_FULL);
    assign addr  = addr_q;
    assign data  = data_q;
    assign young = young_q;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Two-requester arbiter for the register file write port (WE3/A3/WD3).
// Optional build macro: RR_ARB_EN selects round-robin between contested
// different-address slots; otherwise requester 0 has fixed priority.
module regfile_wr_arbiter #(
    parameter int unsigned DATA_W = regfile_wr_arbiter_pkg::DATA_W,
    parameter int unsigned ADDR_W = regfile_wr_arbiter_pkg::ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0_valid,
    input  logic [ADDR_W-1:0]        req0_addr,
    input  logic [DATA_W-1:0]        req0_data,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic [ADDR_W-1:0]        req1_addr,
    input  logic [DATA_W-1:0]        req1_data,
    output logic                     req1_ready,
    output logic                     WE3,
    output logic [ADDR_W-1:0]        A3,
    output logic [DATA_W-1:0]        WD3,
    output logic [(1<<ADDR_W)-1:0]   pend_mask
);
    localparam int unsigned NREG = 1 << ADDR_W;

    logic              full0, full1, young0, young1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] data0, data1;
    logic              gnt0, gnt1, load0, load1;

    // Address-0 writes complete the handshake but never occupy a slot
    assign req0_ready = ~full0 | gnt0;
    assign req1_ready = ~full1 | gnt1;
    assign load0      = req0_valid & req0_ready & (req0_addr != '0);
    assign load1      = req1_valid & req1_ready & (req1_addr != '0);

    wr_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot0 (
        .clk        (clk),
        .rst        (rst),
        .load       (load0),
        .load_addr  (req0_addr),
        .load_data  (req0_data),
        .load_young (full1 & ~gnt1),
        .other_load (load1),
        .grant      (gnt0),
        .full       (full0),
        .addr       (addr0),
        .data       (data0),
        .young      (young0)
    );

    // Slot 1 is younger on a simultaneous load with slot 0
    wr_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot1 (
        .clk        (clk),
        .rst        (rst),
        .load       (load1),
        .load_addr  (req1_addr),
        .load_data  (req1_data),
        .load_young ((full0 & ~gnt0) | load0),
        .other_load (load0),
        .grant      (gnt1),
        .full       (full1),
        .addr       (addr1),
        .data       (data1),
        .young      (young1)
    );

`ifdef RR_ARB_EN
    logic rr_ptr_q;
    logic contested;

    assign contested = full0 & full1 & (addr0 != addr1);

    // Pointer moves to the loser, only on contested different-address grants
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= 1'b0;
        end else if (contested) begin
            rr_ptr_q <= gnt0;
        end
    end
`endif

    // Per-cycle grant among FULL slots
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (full0 && full1) begin
            if (addr0 == addr1) begin
                // Same destination: oldest first keeps write ordering
                gnt0 = ~young0;
                gnt1 = young0;
            end else begin
`ifdef RR_ARB_EN
                gnt0 = ~rr_ptr_q;
                gnt1 = rr_ptr_q;
`else
                gnt0 = 1'b1;
`endif
            end
        end else begin
            gnt0 = full0;
            gnt1 = full1;
        end
    end

    // Registered write-port driver; address/data hold when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WE3 <= 1'b0;
            A3  <= '0;
            WD3 <= '0;
        end else begin
            WE3 <= gnt0 | gnt1;
            if (gnt0) begin
                A3  <= addr0;
                WD3 <= data0;
            end else if (gnt1) begin
                A3  <= addr1;
                WD3 <= data1;
            end
        end
    end

    // Registers with a write in flight, for read-hazard stalls
    always_comb begin
        pend_mask = '0;
        if (full0) pend_mask = pend_mask | (NREG'(1) << addr0);
        if (full1) pend_mask = pend_mask | (NREG'(1) << addr1);
        if (WE3)   pend_mask = pend_mask | (NREG'(1) << A3);
    end

    // young1 only matters through the relative ordering held in young0
    logic unused_young1;
    assign unused_young1 = young1;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed self-checking bench for regfile_wr_arbiter.
module tb_regfile_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic [31:0] pend_mask;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    regfile_wr_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .WE3        (WE3),
        .A3         (A3),
        .WD3        (WD3),
        .pend_mask  (pend_mask)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_addr  = '0;
        req1_addr  = '0;
        req0_data  = '0;
        req1_data  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        #1;
        tests++;
        if ({WE3, A3, WD3} !== 38'd0) begin
            fails++;
            $display("FAIL reset_port: got WE3=%0b A3=%0d WD3=%h want 0/0/0", WE3, A3, WD3);
        end
        tests++;
        if (pend_mask !== 32'h0) begin
            fails++;
            $display("FAIL reset_pend: got %h want 00000000", pend_mask);
        end
        tests++;
        if ({req0_ready, req1_ready} !== 2'b11) begin
            fails++;
            $display("FAIL reset_ready: got %b want 11", {req0_ready, req1_ready});
        end
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_single();
        req0_valid = 1'b1;
        req0_addr  = 5'd5;
        req0_data  = 32'hDEADBEEF;
        tests++;
        if (req0_ready !== 1'b1) begin
            fails++;
            $display("FAIL single_ready: got %0b want 1", req0_ready);
        end
        step();
        idle();
        tests++;
        if (WE3 !== 1'b0 || pend_mask !== 32'h20) begin
            fails++;
            $display("FAIL single_c1: got WE3=%0b pend=%h want 0/00000020", WE3, pend_mask);
        end
        step();
        tests++;
        if ({WE3, A3, WD3} !== {1'b1, 5'd5, 32'hDEADBEEF} || pend_mask !== 32'h20) begin
            fails++;
            $display("FAIL single_c2: got WE3=%0b A3=%0d WD3=%h pend=%h want 1/5/deadbeef/00000020",
                     WE3, A3, WD3, pend_mask);
        end
        step();
        tests++;
        if (WE3 !== 1'b0 || pend_mask !== 32'h0 || A3 !== 5'd5) begin
            fails++;
            $display("FAIL single_c3: got WE3=%0b A3=%0d pend=%h want 0/5/00000000",
                     WE3, A3, pend_mask);
        end
    endtask

    task automatic test_x0_discard();
        req1_valid = 1'b1;
        req1_addr  = 5'd0;
        req1_data  = 32'h1234;
        tests++;
        if (req1_ready !== 1'b1) begin
            fails++;
            $display("FAIL x0_ready: got %0b want 1", req1_ready);
        end
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (WE3 !== 1'b0 || pend_mask !== 32'h0) begin
                fails++;
                $display("FAIL x0_cycle%0d: got WE3=%0b pend=%h want 0/00000000", i, WE3, pend_mask);
            end
            step();
        end
    endtask

    // Both requesters present in the same cycle: req0->3, req1->7
    task automatic do_contest(input logic [4:0] first, input logic [4:0] second);
        req0_valid = 1'b1;
        req0_addr  = 5'd3;
        req0_data  = 32'h0000_0033;
        req1_valid = 1'b1;
        req1_addr  = 5'd7;
        req1_data  = 32'h0000_0077;
        step();
        idle();
        tests++;
        if ({req0_ready, req1_ready} !== ((first == 5'd3) ? 2'b10 : 2'b01)
            || pend_mask !== 32'h88) begin
            fails++;
            $display("FAIL contest_c1: got ready=%b pend=%h want winner=%0d pend=00000088",
                     {req0_ready, req1_ready}, pend_mask, first);
        end
        step();
        tests++;
        if (WE3 !== 1'b1 || A3 !== first) begin
            fails++;
            $display("FAIL contest_first: got WE3=%0b A3=%0d want 1/%0d", WE3, A3, first);
        end
        step();
        tests++;
        if (WE3 !== 1'b1 || A3 !== second || WD3 !== ((second == 5'd3) ? 32'h33 : 32'h77)) begin
            fails++;
            $display("FAIL contest_second: got WE3=%0b A3=%0d WD3=%h want 1/%0d", WE3, A3, WD3,
                     second);
        end
        step();
        tests++;
        if (WE3 !== 1'b0) begin
            fails++;
            $display("FAIL contest_done: got WE3=%0b want 0", WE3);
        end
    endtask

    task automatic test_contention();
        do_contest(5'd3, 5'd7);
`ifdef RR_ARB_EN
        do_contest(5'd7, 5'd3);
`else
        do_contest(5'd3, 5'd7);
`endif
    endtask

    task automatic test_same_addr();
        req0_valid = 1'b1;
        req0_addr  = 5'd4;
        req0_data  = 32'h44;
        req1_valid = 1'b1;
        req1_addr  = 5'd9;
        req1_data  = 32'hAA;
        step();
        req1_valid = 1'b0;
        req0_addr  = 5'd9;
        req0_data  = 32'hBB;
        tests++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            fails++;
            $display("FAIL same_ready: got %b want 10", {req0_ready, req1_ready});
        end
        step();
        idle();
        tests++;
        if ({WE3, A3, WD3} !== {1'b1, 5'd4, 32'h44} || pend_mask !== 32'h210) begin
            fails++;
            $display("FAIL same_c2: got WE3=%0b A3=%0d WD3=%h pend=%h want 1/4/44/00000210",
                     WE3, A3, WD3, pend_mask);
        end
        step();
        tests++;
        if ({WE3, A3, WD3} !== {1'b1, 5'd9, 32'hAA}) begin
            fails++;
            $display("FAIL same_older: got WE3=%0b A3=%0d WD3=%h want 1/9/aa", WE3, A3, WD3);
        end
        step();
        tests++;
        if ({WE3, A3, WD3} !== {1'b1, 5'd9, 32'hBB}) begin
            fails++;
            $display("FAIL same_younger: got WE3=%0b A3=%0d WD3=%h want 1/9/bb", WE3, A3, WD3);
        end
        step();
        tests++;
        if (WE3 !== 1'b0 || pend_mask !== 32'h0) begin
            fails++;
            $display("FAIL same_done: got WE3=%0b pend=%h want 0/00000000", WE3, pend_mask);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 12; k++) begin
            if (k < 8) begin
                req0_valid = 1'b1;
                req0_addr  = 5'(k + 1);
                req0_data  = 32'h100 + 32'(k);
                tests++;
                if (req0_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL stream_ready_%0d: got %0b want 1", k, req0_ready);
                end
            end else begin
                idle();
            end
            if (k >= 2 && k <= 9) begin
                tests++;
                if ({WE3, A3, WD3} !== {1'b1, 5'(k - 1), 32'h100 + 32'(k - 2)}) begin
                    fails++;
                    $display("FAIL stream_write_%0d: got WE3=%0b A3=%0d WD3=%h want 1/%0d/%h",
                             k, WE3, A3, WD3, k - 1, 32'h100 + 32'(k - 2));
                end
            end else if (k >= 10) begin
                tests++;
                if (WE3 !== 1'b0) begin
                    fails++;
                    $display("FAIL stream_tail_%0d: got WE3=%0b want 0", k, WE3);
                end
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        req0_valid = 1'b1;
        req0_addr  = 5'd10;
        req0_data  = 32'hA0;
        req1_valid = 1'b1;
        req1_addr  = 5'd11;
        req1_data  = 32'hB0;
        step();
        idle();
        step();
        tests++;
        if (WE3 !== 1'b1 || A3 !== 5'd10) begin
            fails++;
            $display("FAIL rstmid_pre: got WE3=%0b A3=%0d want 1/10", WE3, A3);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (WE3 !== 1'b0 || pend_mask !== 32'h0 || {req0_ready, req1_ready} !== 2'b11) begin
            fails++;
            $display("FAIL rstmid_async: got WE3=%0b pend=%h ready=%b want 0/00000000/11",
                     WE3, pend_mask, {req0_ready, req1_ready});
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            tests++;
            if (WE3 !== 1'b0 || pend_mask !== 32'h0) begin
                fails++;
                $display("FAIL rstmid_after_%0d: got WE3=%0b pend=%h want 0/00000000",
                         i, WE3, pend_mask);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_x0_discard();
        test_contention();
        test_same_addr();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
